// File: rtl/cyc74_pkg.sv
// Shared constants, FSM state type and syndrome-to-position lookup for the
// (7,4) cyclic code with generator g(x) = 1 + x + x^3.
package cyc74_pkg;

   localparam int N = 7;
   localparam int K = 4;
   localparam logic [3:0] G_POLY   = 4'b1011;
   localparam logic [2:0] POS_NONE = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYND = 2'd1,
      ST_CORR = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   // Syndrome equals x^i mod g(x) for a single error at bit i.
   function automatic logic [2:0] synd_to_pos(input logic [2:0] s);
      logic [2:0] pos;
      case (s)
         3'b001:  pos = 3'd0;
         3'b010:  pos = 3'd1;
         3'b100:  pos = 3'd2;
         3'b011:  pos = 3'd3;
         3'b110:  pos = 3'd4;
         3'b111:  pos = 3'd5;
         3'b101:  pos = 3'd6;
         default: pos = POS_NONE;
      endcase
      return pos;
   endfunction

endpackage

// File: rtl/cyc74_syndrome_lfsr.sv
// Bit-serial division by g(x): after all 7 bits are shifted in (MSB first)
// synd holds the received polynomial mod g(x).
module cyc74_syndrome_lfsr
   import cyc74_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       shift,
   input  logic       bit_in,
   output logic [2:0] synd
);

   logic [2:0] s_q;
   logic       fb_s;

   assign fb_s = s_q[2];
   assign synd = s_q;

   // Remainder register; feedback taps taken from the generator polynomial.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= 3'b000;
      end else if (clr) begin
         s_q <= 3'b000;
      end else if (shift) begin
         s_q <= {s_q[1] ^ (fb_s & G_POLY[2]),
                 s_q[0] ^ (fb_s & G_POLY[1]),
                 bit_in ^ (fb_s & G_POLY[0])};
      end else begin
         s_q <= s_q;
      end
   end

endmodule

// File: rtl/cyc74_decoder.sv
// Serial syndrome decoder for the (7,4) cyclic code: accept, 7-clock syndrome,
// single-bit correction, held result with a saturating error counter.
module cyc74_decoder
   import cyc74_pkg::*;
#(
   parameter bit CORRECT_EN = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     cw_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     data_out,
   output logic [N-1:0]     cw_out,
   output logic             err_det,
   output logic [2:0]       err_pos,
   output logic [CNT_W-1:0] err_cnt
);

   state_e           state_q;
   logic [2:0]       cnt_q;
   logic [N-1:0]     sh_q;
   logic [N-1:0]     cw_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [K-1:0]     data_q;
   logic [N-1:0]     cw_out_q;
   logic             err_det_q;
   logic [2:0]       err_pos_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] err_cnt_d;

   logic [2:0]       synd_s;
   logic [2:0]       pos_s;
   logic [N-1:0]     flip_mask_s;
   logic [N-1:0]     corr_s;
   logic             accept_s;

   assign accept_s = (state_q == ST_IDLE) && in_valid;

   cyc74_syndrome_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept_s),
      .shift  (state_q == ST_SYND),
      .bit_in (sh_q[N-1]),
      .synd   (synd_s)
   );

   assign pos_s = synd_to_pos(synd_s);

   // Flip mask for the located bit; detect-only builds pass the word through.
   always_comb begin
      flip_mask_s = 7'd0;
      if (CORRECT_EN && (pos_s != POS_NONE)) begin
         flip_mask_s = 7'd1 << pos_s;
      end else begin
         flip_mask_s = 7'd0;
      end
   end

   assign corr_s = cw_q ^ flip_mask_s;

   // Saturating increment of the error counter.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((synd_s != 3'd0) && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         sh_q        <= 7'd0;
         cw_q        <= 7'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_q      <= 4'd0;
         cw_out_q    <= 7'd0;
         err_det_q   <= 1'b0;
         err_pos_q   <= POS_NONE;
         err_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  cw_q       <= cw_in;
                  sh_q       <= cw_in;
                  cnt_q      <= 3'd0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SYND;
               end
            end
            ST_SYND: begin
               sh_q  <= {sh_q[N-2:0], 1'b0};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd6) begin
                  state_q <= ST_CORR;
               end
            end
            ST_CORR: begin
               cw_out_q    <= corr_s;
               data_q      <= corr_s[N-1:N-K];
               err_det_q   <= (synd_s != 3'd0);
               err_pos_q   <= pos_s;
               err_cnt_q   <= err_cnt_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_q;
   assign cw_out    = cw_out_q;
   assign err_det   = err_det_q;
   assign err_pos   = err_pos_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cyc74_decoder.sv
// Self-checking bench: a correcting instance and a detect-only instance with a
// 3-bit counter share stimulus; expectations come from polynomial arithmetic.
module tb_cyc74_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [6:0]  cw_in = 7'd0;

   logic        in_ready, out_valid, err_det;
   logic [3:0]  data_out;
   logic [6:0]  cw_out;
   logic [2:0]  err_pos;
   logic [15:0] err_cnt;

   logic        in_ready_b, out_valid_b, err_det_b;
   logic [3:0]  data_out_b;
   logic [6:0]  cw_out_b;
   logic [2:0]  err_pos_b;
   logic [2:0]  err_cnt_b;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;
   int exp_cnt_b = 0;

   always #5 clk = ~clk;

   cyc74_decoder #(.CORRECT_EN(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cw_in(cw_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .cw_out(cw_out),
      .err_det(err_det), .err_pos(err_pos), .err_cnt(err_cnt)
   );

   cyc74_decoder #(.CORRECT_EN(1'b0), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .cw_in(cw_in),
      .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b), .cw_out(cw_out_b),
      .err_det(err_det_b), .err_pos(err_pos_b), .err_cnt(err_cnt_b)
   );

   typedef struct {
      logic [6:0] cw;
      logic [3:0] data;
      logic [2:0] pos;
      logic       det;
      logic [6:0] cwo;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Remainder of w(x) divided by 1 + x + x^3 via long division.
   function automatic logic [2:0] rem7(input logic [6:0] w);
      int r;
      r = int'(w);
      for (int i = 6; i >= 3; i--)
         if (((r >> i) & 1) == 1) r = r ^ (11 << (i - 3));
      return 3'(r);
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] m);
      logic [6:0] c;
      c = {m, 3'b000};
      return c | {4'b0000, rem7(c)};
   endfunction

   function automatic int locate(input logic [2:0] s);
      for (int i = 0; i < 7; i++)
         if (rem7(7'(1 << i)) == s) return i;
      return 7;
   endfunction

   // One decode through both instances; checks against the model, optionally releases.
   task automatic run_word(input logic [6:0] w, input bit release_out);
      int wait_n, lat, p;
      logic [2:0] s;
      logic [6:0] fixed;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin tick(); wait_n++; end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      cw_in    = w;
      tick();
      in_valid = 1'b0;
      cw_in    = 7'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("latency", lat, 8);
      s = rem7(w);
      p = locate(s);
      fixed = (p == 7) ? w : (w ^ 7'(1 << p));
      if (s != 3'd0) begin
         exp_cnt++;
         if (exp_cnt_b < 7) exp_cnt_b++;
      end
      chk("cw_out", cw_out, fixed);
      chk("data_out", data_out, fixed[6:3]);
      chk("err_det", err_det, s != 3'd0);
      chk("err_pos", err_pos, p);
      chk("err_cnt", err_cnt, exp_cnt);
      chk("b_out_valid", out_valid_b, 1);
      chk("b_cw_out", cw_out_b, w);
      chk("b_err_det", err_det_b, s != 3'd0);
      chk("b_err_cnt_sat", err_cnt_b, exp_cnt_b);
      if (release_out) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("out_valid_drop", out_valid, 0);
         chk("in_ready_back", in_ready, 1);
      end
   endtask

   initial begin
      logic [3:0] snap_d;
      logic [6:0] snap_c;
      logic [6:0] w;
      int seen;

      tbl[0] = '{cw: 7'b1010011, data: 4'b1010, pos: 3'd7, det: 1'b0, cwo: 7'b1010011};
      tbl[1] = '{cw: 7'b1011110, data: 4'b1001, pos: 3'd4, det: 1'b1, cwo: 7'b1001110};
      tbl[2] = '{cw: 7'b0001010, data: 4'b0001, pos: 3'd0, det: 1'b1, cwo: 7'b0001011};
      tbl[3] = '{cw: 7'b1111100, data: 4'b1110, pos: 3'd3, det: 1'b1, cwo: 7'b1110100};
      tbl[4] = '{cw: 7'b1111111, data: 4'b1111, pos: 3'd7, det: 1'b0, cwo: 7'b1111111};

      // Reset held for two clocks
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err_pos", err_pos, 7);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_cw_out", cw_out, 0);
      chk("rst_err_det", err_det, 0);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1);

      // Hand-derived vectors
      for (int i = 0; i < 5; i++) begin
         run_word(tbl[i].cw, 1'b0);
         chk("tbl_data", data_out, tbl[i].data);
         chk("tbl_pos", err_pos, tbl[i].pos);
         chk("tbl_det", err_det, tbl[i].det);
         chk("tbl_cw", cw_out, tbl[i].cwo);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end

      // Backpressure: result held, no second word taken
      run_word(7'b1011110, 1'b0);
      snap_d = data_out;
      snap_c = cw_out;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         cw_in    = (k % 2 == 0) ? 7'b0000001 : 7'b1111110;
         tick();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_data_frozen", data_out, snap_d);
         chk("bp_cw_frozen", cw_out, snap_c);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      run_word(7'b0110100, 1'b1);

      // Reset in the middle of the syndrome phase
      in_valid = 1'b1;
      cw_in    = 7'b0100111;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #2;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_err_pos", err_pos, 7);
      exp_cnt   = 0;
      exp_cnt_b = 0;
      tick();
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("midrst_no_output", seen, 0);
      run_word(7'b1111111, 1'b1);

      // Exhaustive: every message with no error and each single-bit error
      for (int m = 0; m < 16; m++) begin
         for (int e = 0; e < 8; e++) begin
            w = encode(4'(m));
            if (e < 7) w = w ^ 7'(1 << e);
            run_word(w, 1'b0);
            chk("exh_msg_recovered", data_out, m);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
         end
      end

      // Random words, including multi-bit errors
      for (int k = 0; k < 40; k++) begin
         run_word(7'($urandom_range(0, 127)), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
